// File: rtl/kl_exec_pkg.sv
// Shared execute-stage definitions: data width, ALU opcodes and
// the multiply sequencer state encoding.
package kl_exec_pkg;

    localparam int DW    = 16;
    localparam int CNT_W = 4;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared execute ALU,
// stalling the pipeline while it owns the adder.
module alu_mul_sequencer
    import kl_exec_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pipe_Ain,
    input  logic [DW-1:0] pipe_Bin,
    input  logic [1:0]    pipe_ALUop,
    input  logic          mul_start,
    input  logic [DW-1:0] mul_a,
    input  logic [DW-1:0] mul_b,
    input  logic [DW-1:0] alu_result,
    output logic [DW-1:0] alu_Ain,
    output logic [DW-1:0] alu_Bin,
    output logic [1:0]    alu_ALUop,
    output logic          stall,
    output logic          mul_busy,
    output logic          mul_done,
    output logic [DW-1:0] mul_result
);

    mul_state_e        state_q;
    logic [DW-1:0]     acc_q;
    logic [DW-1:0]     mcand_q;
    logic [DW-1:0]     mplier_q;
    logic [CNT_W-1:0]  count_q;

    logic [DW-1:0]     mcand_d;
    logic [DW-1:0]     mplier_d;
    logic [CNT_W-1:0]  count_d;
    logic              last_step;

    assign mcand_d   = mcand_q << 1;
    assign mplier_d  = mplier_q >> 1;
    assign count_d   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_step = (mplier_d == '0) || (count_q == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        mcand_q  <= mul_a;
                        mplier_q <= mul_b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= alu_result;
                    end
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_d;
                    if (last_step) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Only BUSY owns the ALU; DONE already hands it back to the pipe.
    always_comb begin
        alu_Ain   = pipe_Ain;
        alu_Bin   = pipe_Bin;
        alu_ALUop = pipe_ALUop;
        if (state_q == ST_BUSY) begin
            alu_Ain   = acc_q;
            alu_Bin   = mcand_q;
            alu_ALUop = ALU_ADD;
        end
    end

    assign stall      = (state_q != ST_IDLE);
    assign mul_busy   = (state_q != ST_IDLE);
    assign mul_done   = (state_q == ST_DONE);
    assign mul_result = acc_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomised bench for alu_mul_sequencer with a behavioural
// multiply model and directed latency/result checks.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] pipe_Ain;
    logic [15:0] pipe_Bin;
    logic [1:0]  pipe_ALUop;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] alu_result;
    logic [15:0] alu_Ain;
    logic [15:0] alu_Bin;
    logic [1:0]  alu_ALUop;
    logic        stall;
    logic        mul_busy;
    logic        mul_done;
    logic [15:0] mul_result;

    alu_mul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_Ain   (pipe_Ain),
        .pipe_Bin   (pipe_Bin),
        .pipe_ALUop (pipe_ALUop),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .alu_result (alu_result),
        .alu_Ain    (alu_Ain),
        .alu_Bin    (alu_Bin),
        .alu_ALUop  (alu_ALUop),
        .stall      (stall),
        .mul_busy   (mul_busy),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared execute ALU lives outside the sequencer.
    always_comb begin
        case (alu_ALUop)
            2'b00:   alu_result = alu_Ain + alu_Bin;
            2'b01:   alu_result = alu_Ain - alu_Bin;
            2'b10:   alu_result = alu_Ain & alu_Bin;
            default: alu_result = ~alu_Bin;
        endcase
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done;
    logic [15:0] done_res;

    // Model: phase 0 idle, 1 busy, 2 done
    bit          chk_en = 0;
    int          ph;
    int          k;
    int          n;
    int unsigned ma;
    int unsigned mb;
    int unsigned res;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int busy_len(int unsigned b);
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    function automatic int unsigned partial(int unsigned a,
                                            int unsigned b,
                                            int kk);
        int unsigned m;
        m = (32'd1 << kk) - 32'd1;
        return (a * (b & m)) & 32'hFFFF;
    endfunction

    task automatic compare();
        case (ph)
            1: begin
                chk("stall", {31'd0, stall}, 32'd1);
                chk("busy", {31'd0, mul_busy}, 32'd1);
                chk("done", {31'd0, mul_done}, 32'd0);
                chk("alu_op", {30'd0, alu_ALUop}, 32'd0);
                chk("alu_A", {16'd0, alu_Ain}, partial(ma, mb, k));
                chk("alu_B", {16'd0, alu_Bin}, (ma << k) & 32'hFFFF);
                chk("res_busy", {16'd0, mul_result}, partial(ma, mb, k));
            end
            default: begin
                chk("stall", {31'd0, stall}, {31'd0, ph == 2});
                chk("busy", {31'd0, mul_busy}, {31'd0, ph == 2});
                chk("done", {31'd0, mul_done}, {31'd0, ph == 2});
                chk("alu_op", {30'd0, alu_ALUop}, {30'd0, pipe_ALUop});
                chk("alu_A", {16'd0, alu_Ain}, {16'd0, pipe_Ain});
                chk("alu_B", {16'd0, alu_Bin}, {16'd0, pipe_Bin});
                chk("result", {16'd0, mul_result}, res);
            end
        endcase
    endtask

    task automatic step(bit r, bit s, logic [15:0] a, logic [15:0] b,
                        logic [15:0] pa, logic [15:0] pb, logic [1:0] op);
        rst        = r;
        mul_start  = s;
        mul_a      = a;
        mul_b      = b;
        pipe_Ain   = pa;
        pipe_Bin   = pb;
        pipe_ALUop = op;
        #1;
        if (chk_en) compare();
        if (mul_done === 1'b1) begin
            last_done = cyc;
            done_res  = mul_result;
        end
        if (r) begin
            ph     = 0;
            res    = 0;
            chk_en = 1;
        end else begin
            case (ph)
                0: if (s) begin
                    ph = 1;
                    k  = 0;
                    ma = a;
                    mb = b;
                    n  = busy_len(b);
                end
                1: begin
                    k++;
                    if (k == n) begin
                        ph  = 2;
                        res = (ma * mb) & 32'hFFFF;
                    end
                end
                default: ph = 0;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_step(bit s);
        step(1'b0, s, 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 2'($urandom));
    endtask

    task automatic run_mul(logic [15:0] a, logic [15:0] b, bit noise,
                           int exp_lat, logic [15:0] exp_res);
        int t0;
        last_done = -1;
        t0 = cyc;
        step(1'b0, 1'b1, a, b, 16'($urandom), 16'($urandom), 2'($urandom));
        for (int i = 0; i < 20 && last_done < 0; i++) begin
            if (noise && i == 1)
                step(1'b0, 1'b1, 16'd7, 16'd9, 16'($urandom),
                     16'($urandom), 2'($urandom));
            else
                idle_step(1'b0);
        end
        chk("latency", last_done - t0, exp_lat);
        chk("mul_res", {16'd0, done_res}, {16'd0, exp_res});
        idle_step(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        mul_start = 1'b0;
        mul_a = '0;
        mul_b = '0;
        pipe_Ain = '0;
        pipe_Bin = '0;
        pipe_ALUop = '0;
        @(negedge clk);
        step(1'b1, 1'b1, 16'd3, 16'd5, 16'd0, 16'd0, 2'd0);
        step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, mul_busy}, 32'd0);
        chk("rst_done", {31'd0, mul_done}, 32'd0);
        chk("rst_res", {16'd0, mul_result}, 32'd0);

        step(1'b0, 1'b0, 16'h1234, 16'h0001, 16'h1234, 16'h0001, 2'b01);
        chk("pass_A", {16'd0, alu_Ain}, 32'h1234);
        chk("pass_B", {16'd0, alu_Bin}, 32'h0001);
        chk("pass_op", {30'd0, alu_ALUop}, 32'd1);
        chk("pass_alu", {16'd0, alu_result}, 32'h1233);
        chk("pass_stall", {31'd0, stall}, 32'd0);

        run_mul(16'd3, 16'd5, 1'b0, 4, 16'h000F);
        run_mul(16'd1234, 16'd0, 1'b0, 2, 16'h0000);
        run_mul(16'hFFFF, 16'hFFFF, 1'b0, 17, 16'h0001);
        run_mul(16'd3, 16'd5, 1'b1, 4, 16'h000F);
        run_mul(16'h8001, 16'h8000, 1'b0, 17, 16'h8000);

        // Reset two cycles into a 3x5 multiply.
        step(1'b0, 1'b1, 16'd3, 16'd5, 16'd0, 16'd0, 2'd0);
        idle_step(1'b0);
        last_done = -1;
        step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        chk("mrst_busy", {31'd0, mul_busy}, 32'd0);
        chk("mrst_res", {16'd0, mul_result}, 32'd0);
        for (int i = 0; i < 6; i++) idle_step(1'b0);
        chk("mrst_nodone", last_done, 32'hFFFF_FFFF);

        for (int i = 0; i < 800; i++) begin
            logic [15:0] b;
            case ($urandom % 4)
                0:       b = 16'd0;
                1:       b = 16'($urandom % 16);
                2:       b = 16'($urandom);
                default: b = 16'($urandom) | 16'h8000;
            endcase
            step(($urandom % 100) == 0, ($urandom % 5) == 0,
                 16'($urandom), b, 16'($urandom), 16'($urandom),
                 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port pipe_Ain, input, 16, pipeline-side ALU A operand.
REQ-004 SHALL have port pipe_Bin, input, 16, pipeline-side ALU B operand.
REQ-005 SHALL have port pipe_ALUop, input, 2, pipeline-side ALU op: 00 add, 01 sub, 10 and, 11 not-B.
REQ-006 SHALL have port mul_start, input, 1, multiply request, one-cycle pulse or level.
REQ-007 SHALL have ports mul_a and mul_b, input, 16 each, multiplicand and multiplier.
REQ-008 SHALL have port alu_result, input, 16, output of the shared execute ALU.
REQ-009 SHALL have ports alu_Ain, alu_Bin, alu_ALUop, output, 16/16/2, drive the shared ALU.
REQ-010 SHALL have port stall, output, 1, freezes upstream pipeline registers.
REQ-011 SHALL have ports mul_busy and mul_done, output, 1 each, status and one-cycle completion pulse.
REQ-012 SHALL have port mul_result, output, 16, low 16 bits of product.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL, in IDLE, pass pipe_Ain/pipe_Bin/pipe_ALUop unchanged and combinationally to alu_Ain/alu_Bin/alu_ALUop.
REQ-015 SHALL, in IDLE with mul_start=1, load mcand<=mul_a, mplier<=mul_b, acc<=0, count<=0, and go to BUSY.
REQ-016 SHALL, in BUSY, drive alu_Ain=acc, alu_Bin=mcand, alu_ALUop=00, ignoring pipe_* inputs.
REQ-017 SHALL, each BUSY cycle, update acc<=alu_result if mplier[0]=1 (else hold), mcand<=mcand<<1, mplier<=mplier>>1 (logical), count<=count+1.
REQ-018 SHALL leave BUSY for DONE when the shifted mplier is zero or count=15, so BUSY lasts 1 to 16 cycles.
REQ-019 SHALL discard carries beyond bit 15 (product modulo 2^16; signed and unsigned give identical low bits).
REQ-020 SHALL hold DONE for exactly one cycle with mul_done=1, then return to IDLE.
REQ-021 SHALL drive mul_result from acc, valid from DONE and held until the next accepted start.
REQ-022 SHALL drive stall=1 and mul_busy=1 in BUSY and DONE, and 0 in IDLE.
REQ-023 SHALL ignore mul_start in BUSY and DONE; a level held through DONE is accepted in the following IDLE cycle.
REQ-024 SHALL give a total latency from start cycle T to mul_done of (BUSY cycles + 1).
REQ-025 SHALL, in DONE, mux pipe_* to the ALU so the stalled instruction sees valid operands.

Reset
REQ-026 SHALL, with rst=1 at any edge (including mid-BUSY), go to IDLE and clear acc, mcand, mplier, count, and mul_result to 0.
REQ-027 SHALL drive stall=0, mul_busy=0, and mul_done=0 in the cycle after reset; a mul_start coincident with rst is dropped.

Structure
REQ-028 SHALL import the state enum, ALUop constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT), and data width 16 from shared package kl_exec_pkg.
REQ-029 SHALL be flat (FSM, counter, operand registers, and ALU input mux), with the ALU external and shared with the execute stage.

Verification
REQ-030 SHALL verify: mul_a=3, mul_b=5, start at T -> BUSY T+1..T+3, mul_done at T+4, mul_result=0x000F.
REQ-031 SHALL verify: mul_b=0 -> one BUSY cycle, mul_done at T+2, mul_result=0x0000.
REQ-032 SHALL verify: mul_a=0xFFFF, mul_b=0xFFFF -> 16 BUSY cycles, mul_done at T+17, mul_result=0x0001.
REQ-033 SHALL verify: IDLE with pipe_Ain=0x1234, pipe_Bin=0x0001, op=01 -> alu_* mirror pipe_*, stall=0 throughout.
REQ-034 SHALL verify: second mul_start pulse during BUSY -> ignored, first result unchanged.
REQ-035 SHALL verify: rst at T+2 of a 3x5 multiply -> IDLE next cycle, mul_result=0, stall=0, no mul_done.
